fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arbiter.sv | 127 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin owner arbiter for the async FIFO write port (wclk domain).
// Optional feature macro: ARB_BURST_LOCK_EN (owner keeps grant for up to MAX_BURST words).
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 16
) (
  input  logic               wclk,
  input  logic               wrst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] wdata_in,
  input  logic               wfull,
  output logic [NREQ-1:0]    ack,
  output logic               winc,
  output logic [DW-1:0]      wdata,
  output logic [NREQ-1:0]    grant,
  output logic               busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
`ifdef ARB_BURST_LOCK_EN
  localparam int EFF_BURST = MAX_BURST;
`else
  localparam int EFF_BURST = 1;
`endif

  typedef enum logic {IDLE, OWN} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   last_q, last_d;
  logic [CW-1:0]   burst_cnt_q, burst_cnt_d;

  logic            own;
  logic            own_req;
  logic            winc_c;
  logic            release_c;
  logic [NREQ-1:0] others;
  logic [IW-1:0]   pick;
  logic [DW-1:0]   wdata_c;

  // Scans from the far end of the search order so the earliest candidate is assigned last.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] mask,
                                            input logic [IW-1:0]   from);
    logic [IW-1:0] sel;
    int            idx;
    rr_pick = from;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(from) + k) % NREQ;
      sel = IW'(idx);
      if (mask[sel]) rr_pick = sel;
    end
  endfunction

  always_comb begin
    own       = (state_q == OWN);
    own_req   = |(req & grant_q);
    winc_c    = own & own_req & ~wfull;
    others    = req & ~grant_q;
    release_c = ~own_req | (winc_c && (burst_cnt_q + CW'(1) == CW'(EFF_BURST)));
    wdata_c   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (own && grant_q[i]) wdata_c = wdata_in[i*DW +: DW];
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    pick        = last_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          pick        = rr_pick(req, last_q);
          grant_d     = NREQ'(1) << pick;
          last_d      = pick;
          burst_cnt_d = '0;
          state_d     = OWN;
        end
      end
      OWN: begin
        if (winc_c) burst_cnt_d = burst_cnt_q + CW'(1);
        if (release_c) begin
          burst_cnt_d = '0;
          if (|others) begin
            // Direct handover: no idle bubble between owners.
            pick    = rr_pick(others, last_q);
            grant_d = NREQ'(1) << pick;
            last_d  = pick;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        grant_d     = '0;
        burst_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      last_q      <= IW'(NREQ - 1);
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign winc  = winc_c;
  assign ack   = grant_q & {NREQ{winc_c}};
  assign wdata = wdata_c;
  assign grant = grant_q;
  assign busy  = own;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter (honours ARB_BURST_LOCK_EN).
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int DW = 8;
  localparam int MAX_BURST = 4;
`ifdef ARB_BURST_LOCK_EN
  localparam int EB = MAX_BURST;
`else
  localparam int EB = 1;
`endif

  logic               wclk;
  logic               wrst_n;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] wdata_in;
  logic               wfull;
  logic [NREQ-1:0]    ack;
  logic               winc;
  logic [DW-1:0]      wdata;
  logic [NREQ-1:0]    grant;
  logic               busy;

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req(req), .wdata_in(wdata_in), .wfull(wfull),
    .ack(ack), .winc(winc), .wdata(wdata), .grant(grant), .busy(busy)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   rem[NREQ];
  int   cnt[NREQ];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [7:0] word_of(int i, int k);
    return 8'(8'hA0 + i * 16 + k);
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req[i] = (rem[i] > 0);
      wdata_in[i*DW +: DW] = word_of(i, cnt[i]);
    end
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = 0;
      cnt[i] = 0;
    end
    sb.delete();
    drive();
  endtask

  // Word-level expectation: owners in round-robin order from requester 0, up to EB words each.
  task automatic gen_expected();
    int   r[NREQ];
    int   c[NREQ];
    int   last;
    int   pick;
    int   n;
    exp_t e;
    last = NREQ - 1;
    for (int i = 0; i < NREQ; i++) begin
      r[i] = rem[i];
      c[i] = cnt[i];
    end
    for (int guard = 0; guard < 64; guard++) begin
      pick = -1;
      for (int k = 1; k <= NREQ; k++) begin
        if (pick < 0 && r[(last + k) % NREQ] > 0) pick = (last + k) % NREQ;
      end
      if (pick < 0) break;
      n = (r[pick] < EB) ? r[pick] : EB;
      for (int j = 0; j < n; j++) begin
        e.idx  = 2'(pick);
        e.data = word_of(pick, c[pick]);
        sb.push_back(e);
        c[pick]++;
        r[pick]--;
      end
      last = pick;
    end
  endtask

  task automatic tick(output bit wrote);
    exp_t            e;
    logic [NREQ-1:0] ack_seen;
    @(negedge wclk);
    n_cmp++;
    if (ack !== (grant & {NREQ{winc}})) begin
      n_bad++;
      $display("FAIL ack_vs_grant: ack=%b grant=%b winc=%b", ack, grant, winc);
    end
    wrote = (winc === 1'b1);
    if (wrote) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: ack=%b wdata=%h, none expected", ack, wdata);
      end else begin
        e = sb.pop_front();
        if (ack !== (NREQ'(1) << e.idx) || wdata !== e.data) begin
          n_bad++;
          $display("FAIL write_word: ack=%b wdata=%h, required ack=%b wdata=%h",
                   ack, wdata, NREQ'(1) << e.idx, e.data);
        end
      end
    end
    ack_seen = ack;
    @(posedge wclk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (ack_seen[i] === 1'b1) begin
        rem[i]--;
        cnt[i]++;
      end
    end
    drive();
  endtask

  task automatic run_until_empty(input int budget);
    bit w;
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick(w);
      n++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d words outstanding, required 0", sb.size());
    end
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    wfull  = 1'b0;
    clear_reqs();
    repeat (2) @(posedge wclk);
    #1;
    wrst_n = 1'b1;
  endtask

  task automatic test_reset();
    wrst_n = 1'b0;
    wfull  = 1'b0;
    clear_reqs();
    for (int i = 0; i < NREQ; i++) rem[i] = 1;
    drive();
    @(negedge wclk);
    n_cmp++;
    if (grant !== '0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_grant: grant=%b busy=%b, required 0000/0", grant, busy);
    end
    n_cmp++;
    if (winc !== 1'b0 || ack !== '0 || wdata !== '0) begin
      n_bad++;
      $display("FAIL reset_wport: winc=%b ack=%b wdata=%h, required 0/0000/00", winc, ack, wdata);
    end
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;
    gen_expected();
    @(negedge wclk);
    n_cmp++;
    if (grant !== '0 || winc !== 1'b0) begin
      n_bad++;
      $display("FAIL pre_arb: grant=%b winc=%b, required 0000/0", grant, winc);
    end
    @(posedge wclk);
    #1;
    n_cmp++;
    if (grant !== 4'b0001 || busy !== 1'b1 || winc !== 1'b1) begin
      n_bad++;
      $display("FAIL first_grant: grant=%b busy=%b winc=%b, required 0001/1/1", grant, busy, winc);
    end
    run_until_empty(40);
  endtask

  task automatic test_round_robin();
    bit w;
    int nw;
    int first;
    do_reset();
    rem[0] = 6;
    rem[1] = 6;
    rem[3] = 6;
    drive();
    gen_expected();
    nw = 0;
    first = 0;
    for (int cyc = 0; cyc < 20 && nw < 6; cyc++) begin
      tick(w);
      if (w) begin
        nw++;
        if (nw == 1) first = cyc;
        if (nw == 6) begin
          n_cmp++;
          if (cyc - first != 5) begin
            n_bad++;
            $display("FAIL no_bubble: 6 words took %0d cycles, required 6", cyc - first + 1);
          end
        end
      end
    end
    run_until_empty(80);
  endtask

  task automatic test_wfull();
    bit              w;
    int              nw;
    logic [NREQ-1:0] g;
    do_reset();
    rem[0] = 4;
    rem[2] = 4;
    drive();
    gen_expected();
    nw = 0;
    for (int cyc = 0; cyc < 10 && nw < 2; cyc++) begin
      tick(w);
      if (w) nw++;
    end
    g = grant;
    n_cmp++;
    if (g !== 4'b0001) begin
      n_bad++;
      $display("FAIL full_owner: grant=%b, required 0001", g);
    end
    wfull = 1'b1;
    repeat (3) begin
      @(negedge wclk);
      n_cmp++;
      if (winc !== 1'b0 || ack !== '0 || grant !== g) begin
        n_bad++;
        $display("FAIL full_hold: winc=%b ack=%b grant=%b, required 0/0000/%b", winc, ack, grant, g);
      end
      @(posedge wclk);
      #1;
    end
    wfull = 1'b0;
    run_until_empty(40);
  endtask

  task automatic test_handover();
    bit w;
    do_reset();
    rem[1] = 1;
    rem[3] = 3;
    drive();
    gen_expected();
    for (int cyc = 0; cyc < 6 && rem[1] != 0; cyc++) tick(w);
    for (int k = 0; k < 2 && grant !== 4'b1000; k++) tick(w);
    n_cmp++;
    if (grant !== 4'b1000 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL handover: grant=%b busy=%b, required 1000/1", grant, busy);
    end
    run_until_empty(30);
    for (int k = 0; k < 2 && busy !== 1'b0; k++) tick(w);
    tick(w);
    n_cmp++;
    if (busy !== 1'b0 || grant !== '0 || winc !== 1'b0) begin
      n_bad++;
      $display("FAIL go_idle: busy=%b grant=%b winc=%b, required 0/0000/0", busy, grant, winc);
    end
  endtask

  task automatic test_reset_mid_burst();
    bit w;
    do_reset();
    rem[2] = 10;
    drive();
    gen_expected();
    for (int cyc = 0; cyc < 20 && cnt[2] < 3; cyc++) tick(w);
    for (int k = 0; k < 3 && winc !== 1'b1; k++) tick(w);
    n_cmp++;
    if (winc !== 1'b1 || grant !== 4'b0100) begin
      n_bad++;
      $display("FAIL mid_burst: winc=%b grant=%b, required 1/0100", winc, grant);
    end
    #2;
    wrst_n = 1'b0;
    #1;
    n_cmp++;
    if (grant !== '0 || busy !== 1'b0 || winc !== 1'b0 || ack !== '0 || wdata !== '0) begin
      n_bad++;
      $display("FAIL async_reset: grant=%b busy=%b winc=%b ack=%b wdata=%h, required all 0",
               grant, busy, winc, ack, wdata);
    end
    clear_reqs();
    rem[0] = 2;
    rem[2] = 2;
    drive();
    gen_expected();
    #2;
    wrst_n = 1'b1;
    @(posedge wclk);
    #1;
    n_cmp++;
    if (grant !== 4'b0001) begin
      n_bad++;
      $display("FAIL post_reset_winner: grant=%b, required 0001", grant);
    end
    run_until_empty(30);
  endtask

  initial begin
    wrst_n = 1'b0;
    wfull = 1'b0;
    req = '0;
    wdata_in = '0;
    test_reset();
    test_round_robin();
    test_wfull();
    test_handover();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
